// File: rtl/pipe_mux_nx1.sv
// Registered N:1 channel multiplexer with valid/ready handshake and a sticky bad-select flag.
// Define MUX_SKID_EN for a 2-entry skid buffer; the default build uses a single output register.
module pipe_mux_nx1 #(
  parameter int WIDTH  = 5,
  parameter int NUM_IN = 2,
  parameter int SEL_W  = 1
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic [NUM_IN*WIDTH-1:0] in_data,
  input  logic [SEL_W-1:0]        in_sel,
  input  logic                    in_valid,
  output logic                    in_ready,
  output logic [WIDTH-1:0]        out_data,
  output logic [SEL_W-1:0]        out_sel,
  output logic                    out_valid,
  input  logic                    out_ready,
  output logic                    sel_err,
  input  logic                    err_clr
);

  localparam logic [SEL_W:0] NUM_IN_L = (SEL_W+1)'(NUM_IN);

  // Unused select codes deliver zeros instead of reading past the packed bus.
  function automatic logic [WIDTH-1:0] pick_chan(input logic [NUM_IN*WIDTH-1:0] d,
                                                 input logic [SEL_W-1:0]        s);
    logic [WIDTH-1:0] r;
    r = '0;
    for (int k = 0; k < NUM_IN; k++) begin
      if ({1'b0, s} == (SEL_W+1)'(k)) r = d[k*WIDTH +: WIDTH];
    end
    return r;
  endfunction

`ifdef MUX_SKID_EN
  typedef enum logic [1:0] {EMPTY = 2'd0, ONE = 2'd1, TWO = 2'd2} state_t;
`else
  typedef enum logic [1:0] {EMPTY = 2'd0, ONE = 2'd1} state_t;
`endif

  state_t state_q, state_d;

  logic             accept;
  logic             consume;
  logic             oob_p0;
  logic [WIDTH-1:0] mux_data_p0;
  logic             load_head;
  logic [WIDTH-1:0] head_data_p1;
  logic [SEL_W-1:0] head_sel_p1;
  logic             vld_p1;

  // ---- stage 0: channel select and handshake decode ----
  assign mux_data_p0 = pick_chan(in_data, in_sel);
  assign oob_p0      = ({1'b0, in_sel} >= NUM_IN_L);
  assign vld_p1      = (state_q != EMPTY);
  assign accept      = in_valid && in_ready;
  assign consume     = vld_p1 && out_ready;

`ifdef MUX_SKID_EN
  logic             load_skid;
  logic             move_skid;
  logic [WIDTH-1:0] skid_data_p1;
  logic [SEL_W-1:0] skid_sel_p1;

  // Ready comes only from the registered state, breaking the out_ready -> in_ready path.
  assign in_ready = (state_q != TWO);

  always_comb begin
    state_d   = state_q;
    load_head = 1'b0;
    load_skid = 1'b0;
    move_skid = 1'b0;
    case (state_q)
      EMPTY: begin
        if (accept) begin
          load_head = 1'b1;
          state_d   = ONE;
        end
      end
      ONE: begin
        if (accept && consume) begin
          load_head = 1'b1;
        end else if (accept) begin
          load_skid = 1'b1;
          state_d   = TWO;
        end else if (consume) begin
          state_d   = EMPTY;
        end
      end
      TWO: begin
        if (consume) begin
          move_skid = 1'b1;
          state_d   = ONE;
        end
      end
      default: state_d = EMPTY;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      skid_data_p1 <= '0;
      skid_sel_p1  <= '0;
    end else if (load_skid) begin
      skid_data_p1 <= mux_data_p0;
      skid_sel_p1  <= in_sel;
    end
  end
`else
  logic             move_skid;
  logic [WIDTH-1:0] skid_data_p1;
  logic [SEL_W-1:0] skid_sel_p1;

  assign move_skid    = 1'b0;
  assign skid_data_p1 = '0;
  assign skid_sel_p1  = '0;
  assign in_ready     = !vld_p1 || out_ready;

  always_comb begin
    state_d   = state_q;
    load_head = 1'b0;
    case (state_q)
      EMPTY: begin
        if (accept) begin
          load_head = 1'b1;
          state_d   = ONE;
        end
      end
      ONE: begin
        if (accept) begin
          load_head = 1'b1;
        end else if (consume) begin
          state_d   = EMPTY;
        end
      end
      default: state_d = EMPTY;
    endcase
  end
`endif

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state_q <= EMPTY;
    else        state_q <= state_d;
  end

  // ---- stage 1: output register ----
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      head_data_p1 <= '0;
      head_sel_p1  <= '0;
    end else if (load_head) begin
      head_data_p1 <= mux_data_p0;
      head_sel_p1  <= in_sel;
    end else if (move_skid) begin
      head_data_p1 <= skid_data_p1;
      head_sel_p1  <= skid_sel_p1;
    end
  end

  // A new bad accept wins over a simultaneous clear.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) sel_err <= 1'b0;
    else        sel_err <= (sel_err && !err_clr) || (accept && oob_p0);
  end

  assign out_data  = head_data_p1;
  assign out_sel   = head_sel_p1;
  assign out_valid = vld_p1;

endmodule

// File: tb/tb_pipe_mux_nx1.sv
// Directed-vector and scoreboard bench for pipe_mux_nx1 (NUM_IN=5, WIDTH=8).
module tb_pipe_mux_nx1;

  localparam int W  = 8;
  localparam int N  = 5;
  localparam int SW = 3;

  logic          clk = 1'b0;
  logic          rst_n;
  logic [N*W-1:0] in_data;
  logic [SW-1:0] in_sel;
  logic          in_valid;
  logic          in_ready;
  logic [W-1:0]  out_data;
  logic [SW-1:0] out_sel;
  logic          out_valid;
  logic          out_ready;
  logic          sel_err;
  logic          err_clr;

  int total = 0;
  int bad   = 0;

  pipe_mux_nx1 #(.WIDTH(W), .NUM_IN(N), .SEL_W(SW)) dut (
    .clk(clk), .rst_n(rst_n), .in_data(in_data), .in_sel(in_sel),
    .in_valid(in_valid), .in_ready(in_ready), .out_data(out_data),
    .out_sel(out_sel), .out_valid(out_valid), .out_ready(out_ready),
    .sel_err(sel_err), .err_clr(err_clr)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic       v;
    logic [2:0] s;
    logic       clr;
    logic       ev;
    logic [7:0] ed;
    logic       ee;
  } vec_t;

  vec_t tbl[12];
  logic [10:0] q[$];

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
    end
  endtask

  function automatic logic [7:0] ref_pick(input logic [N*W-1:0] d, input logic [2:0] s);
    logic [N*W-1:0] t;
    if (s >= 3'd5) return 8'h00;
    t = d >> (32'(s) * 8);
    return t[7:0];
  endfunction

  initial begin
    logic acc, cons, err_m, exp_rdy;
    int items, cyc;

    tbl[0]  = '{1'b1, 3'd2, 1'b0, 1'b1, 8'h33, 1'b0};
    tbl[1]  = '{1'b0, 3'd0, 1'b0, 1'b0, 8'h00, 1'b0};
    tbl[2]  = '{1'b1, 3'd0, 1'b0, 1'b1, 8'h11, 1'b0};
    tbl[3]  = '{1'b1, 3'd4, 1'b0, 1'b1, 8'h55, 1'b0};
    tbl[4]  = '{1'b1, 3'd5, 1'b0, 1'b1, 8'h00, 1'b1};
    tbl[5]  = '{1'b0, 3'd0, 1'b0, 1'b0, 8'h00, 1'b1};
    tbl[6]  = '{1'b0, 3'd0, 1'b1, 1'b0, 8'h00, 1'b0};
    tbl[7]  = '{1'b1, 3'd7, 1'b0, 1'b1, 8'h00, 1'b1};
    tbl[8]  = '{1'b1, 3'd6, 1'b1, 1'b1, 8'h00, 1'b1};
    tbl[9]  = '{1'b0, 3'd0, 1'b1, 1'b0, 8'h00, 1'b0};
    tbl[10] = '{1'b1, 3'd1, 1'b1, 1'b1, 8'h22, 1'b0};
    tbl[11] = '{1'b1, 3'd3, 1'b0, 1'b1, 8'h44, 1'b0};

    rst_n = 1'b0; in_data = {8'h55, 8'h44, 8'h33, 8'h22, 8'h11};
    in_sel = '0; in_valid = 1'b0; out_ready = 1'b1; err_clr = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    chk("rst_valid", 32'(out_valid), 0);
    chk("rst_err",   32'(sel_err),   0);
    chk("rst_data",  32'(out_data),  0);
    chk("rst_sel",   32'(out_sel),   0);
    rst_n = 1'b1;
    #1;
    chk("rst_ready", 32'(in_ready), 1);

    // table vectors, downstream always ready
    for (int i = 0; i < 12; i++) begin
      in_valid = tbl[i].v; in_sel = tbl[i].s; err_clr = tbl[i].clr; out_ready = 1'b1;
      tick();
      chk("vec_valid", 32'(out_valid), 32'(tbl[i].ev));
      chk("vec_err",   32'(sel_err),   32'(tbl[i].ee));
      chk("vec_ready", 32'(in_ready),  1);
      if (tbl[i].ev) begin
        chk("vec_data", 32'(out_data), 32'(tbl[i].ed));
        chk("vec_sel",  32'(out_sel),  32'(tbl[i].s));
      end
    end
    in_valid = 1'b0; err_clr = 1'b0;
    tick();
    chk("drain_valid", 32'(out_valid), 0);

    // ten back-to-back items with downstream ready
    for (int k = 0; k < 10; k++) begin
      in_valid = 1'b1; in_sel = 3'(k % 5);
      #1;
      chk("stream_ready", 32'(in_ready), 1);
      tick();
      chk("stream_valid", 32'(out_valid), 1);
      chk("stream_data",  32'(out_data),  32'(8'h11 * (k % 5 + 1)));
    end
    in_valid = 1'b0;
    tick();
    chk("stream_end", 32'(out_valid), 0);

    // backpressure
    out_ready = 1'b0; in_valid = 1'b1; in_sel = 3'd0;
    tick();
    chk("bp_valid0", 32'(out_valid), 1);
    chk("bp_data0",  32'(out_data),  32'h11);
`ifdef MUX_SKID_EN
    chk("bp_ready_one", 32'(in_ready), 1);
    in_sel = 3'd1;
    tick();
    chk("bp_ready_two", 32'(in_ready), 0);
    chk("bp_hold1",     32'(out_data), 32'h11);
    in_sel = 3'd2;
    tick();
    chk("bp_hold2",     32'(out_data), 32'h11);
    chk("bp_ready_two2", 32'(in_ready), 0);
    out_ready = 1'b1;
    tick();
    chk("bp_second",    32'(out_data), 32'h22);
    chk("bp_ready_back", 32'(in_ready), 1);
    tick();
    chk("bp_third",     32'(out_data), 32'h33);
    chk("bp_third_v",   32'(out_valid), 1);
`else
    chk("bp_ready_full", 32'(in_ready), 0);
    in_sel = 3'd1;
    tick();
    chk("bp_hold1", 32'(out_data), 32'h11);
    chk("bp_hold1_sel", 32'(out_sel), 0);
    out_ready = 1'b1;
    #1;
    chk("bp_ready_comb", 32'(in_ready), 1);
    tick();
    chk("bp_second", 32'(out_data), 32'h22);
`endif
    in_valid = 1'b0;
    tick();
    chk("bp_end", 32'(out_valid), 0);

    // asynchronous reset while an item is held
    out_ready = 1'b0; in_valid = 1'b1; in_sel = 3'd5;
    tick();
    chk("ar_valid", 32'(out_valid), 1);
    chk("ar_err",   32'(sel_err),   1);
    in_valid = 1'b0;
    #2 rst_n = 1'b0;
    #1;
    chk("ar_valid_clr", 32'(out_valid), 0);
    chk("ar_err_clr",   32'(sel_err),   0);
    chk("ar_sel_clr",   32'(out_sel),   0);
    rst_n = 1'b1;
    out_ready = 1'b1; in_valid = 1'b1; in_sel = 3'd1;
    #1;
    chk("ar_ready", 32'(in_ready), 1);
    tick();
    chk("ar_first_v", 32'(out_valid), 1);
    chk("ar_first_d", 32'(out_data),  32'h22);
    in_valid = 1'b0;
    tick();
    chk("ar_end", 32'(out_valid), 0);

    // random traffic against a queue scoreboard
    err_m = 1'b0; items = 0; cyc = 0;
    while (items < 10000 && cyc < 60000) begin
      in_valid  = ($urandom_range(0, 99) < 70);
      in_sel    = 3'($urandom_range(0, 7));
      in_data   = 40'({$urandom(), $urandom()});
      err_clr   = ($urandom_range(0, 19) == 0);
      out_ready = ($urandom_range(0, 99) < 60);
      #1;
      acc  = in_valid && in_ready;
      cons = out_valid && out_ready;
`ifdef MUX_SKID_EN
      exp_rdy = (q.size() < 2);
`else
      exp_rdy = (q.size() == 0) || out_ready;
`endif
      chk("rnd_ready", 32'(in_ready), 32'(exp_rdy));
      chk("rnd_valid", 32'(out_valid), 32'(q.size() != 0));
      if (cons && q.size() != 0) begin
        chk("rnd_data", 32'(out_data), 32'(q[0][7:0]));
        chk("rnd_sel",  32'(out_sel),  32'(q[0][10:8]));
      end
      @(posedge clk);
      if (cons && q.size() != 0) begin
        void'(q.pop_front());
        items++;
      end
      if (acc) q.push_back({in_sel, ref_pick(in_data, in_sel)});
      err_m = (err_m && !err_clr) || (acc && (in_sel >= 3'd5));
      #1;
      chk("rnd_err", 32'(sel_err), 32'(err_m));
      cyc++;
    end
    chk("rnd_budget", 32'(items >= 10000), 1);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/pipe_mux_nx1.md
PIPE_MUX_NX1 -- requirements
Module: pipe_mux_nx1

Interface
REQ-001 Parameter: WIDTH, default 5, data width of each input channel and of the output.
REQ-002 Parameter: NUM_IN, default 2, number of input channels, legal range 2..16.
REQ-003 Parameter: SEL_W, default 1, select width, SHALL equal ceil(log2(NUM_IN)).
REQ-004 Port: clk  input  1  the single clock; all state updates on its rising edge.
REQ-005 Port: rst_n  input  1  asynchronous, active-low reset.
REQ-006 Port: in_data  input  NUM_IN*WIDTH  packed channels; channel k occupies bits [k*WIDTH +: WIDTH].
REQ-007 Port: in_sel  input  SEL_W  binary channel select, sampled with in_data.
REQ-008 Port: in_valid  input  1  upstream offers in_data/in_sel.
REQ-009 Port: in_ready  output  1  block can accept this cycle.
REQ-010 Port: out_data  output  WIDTH  selected, registered channel data.
REQ-011 Port: out_sel  output  SEL_W  in_sel value that produced out_data.
REQ-012 Port: out_valid  output  1  out_data/out_sel hold a valid item.
REQ-013 Port: out_ready  input  1  downstream consumes the item when high with out_valid.
REQ-014 Port: sel_err  output  1  sticky flag: an out-of-range select was accepted.
REQ-015 Port: err_clr  input  1  synchronous clear of sel_err.

Function
REQ-016 Accept SHALL occur when in_valid and in_ready are both high on a rising edge; consume when out_valid and out_ready are both high.
REQ-017 Latency SHALL be exactly one cycle: an item accepted at edge N appears on out_data with out_valid high after edge N when the output stage is empty.
REQ-018 Selected data SHALL be channel in_sel when in_sel < NUM_IN; otherwise the stored data SHALL be all zeros.
REQ-019 An accepted item with in_sel >= NUM_IN SHALL still transfer (not dropped) and SHALL set sel_err at the same edge.
REQ-020 sel_err SHALL remain set until err_clr is high on an edge; simultaneous err_clr and a new out-of-range accept SHALL leave sel_err set.
REQ-021 Items SHALL leave in acceptance order; none SHALL be duplicated or lost.
REQ-022 out_data and out_sel SHALL remain stable while out_valid is high and out_ready is low.
REQ-023 in_ready SHALL depend only on registered state, never combinationally on out_ready (when MUX_SKID_EN defined).
REQ-024 Non-power-of-two NUM_IN SHALL be supported; unused select codes follow REQ-018/REQ-019.

Reset
REQ-025 rst_n low SHALL immediately, without waiting for clk, force out_valid=0, out_data=0, out_sel=0, sel_err=0 and storage state EMPTY.
REQ-026 Reset mid-transfer SHALL discard all held items; first accept after rst_n release behaves as from empty.
REQ-027 in_ready SHALL be high in the first cycle after reset release.

Configuration
REQ-028 Macro MUX_SKID_EN SHALL select the output buffering.
REQ-029 With MUX_SKID_EN defined: 2-entry skid buffer, states EMPTY, ONE, TWO; EMPTY->ONE on accept; ONE->TWO on accept without consume; ONE->EMPTY on consume without accept; ONE stays ONE on accept+consume; TWO->ONE on consume; in_ready = (state != TWO); full throughput under continuous out_ready.
REQ-030 Without MUX_SKID_EN: single output register, in_ready = !out_valid || out_ready (combinational path permitted), states EMPTY and ONE only; REQ-023 waived.

Verification
REQ-031 NUM_IN=4, WIDTH=8, out_ready=1, in_data={8'h44,8'h33,8'h22,8'h11}, in_sel=2, one accept -> next cycle out_data=8'h33, out_sel=2, out_valid=1, then out_valid=0.
REQ-032 NUM_IN=3, accept in_sel=3 -> out_data=0, out_valid=1, sel_err=1 held; err_clr pulse -> sel_err=0; err_clr with concurrent in_sel=3 accept -> sel_err stays 1.
REQ-033 MUX_SKID_EN defined, out_ready=0, stream sel 0,1,0 -> two accepted, in_ready=0 in TWO; raise out_ready -> outputs in order ch0, ch1, then third item accepted.
REQ-034 Without MUX_SKID_EN, out_ready held 1, in_valid held 1 for 10 cycles -> 10 items out in 10 consecutive cycles, in_ready=1 throughout.
REQ-035 Hold out_ready=0 with out_valid=1, assert rst_n=0 between edges -> out_valid=0 and sel_err=0 immediately; after release, in_ready=1 and first accept emerges after one cycle.
REQ-036 Random in_valid/out_ready, 10000 items, NUM_IN=5 -> scoreboard: order preserved, no loss/duplication, data matches REQ-018.
